// File: rtl/mem_access_unit_if.sv
// Data-RAM request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// Pipeline memory-access stage: RAM req/ack transaction, stall request, load extraction.
// Optional MEM_ACCESS_ALIGN_CHECK_EN adds an alignment check and addr_err_out.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_next_stage,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  input  logic        hilo_write_en_in,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  mem_access_unit_if.master ram,
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  output logic        addr_err_out,
`endif
  output logic        stall_request,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out,
  output logic        hilo_write_en_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic        pending;
  logic        addr_err;
  logic        start;
  logic [31:0] wdata_rep;
  logic [31:0] load_data;
  logic [31:0] load_buf;

  assign pending = mem_read_flag_in | mem_write_flag_in;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  always_comb begin
    addr_err = 1'b0;
    if (pending && state == IDLE) begin
      case (mem_sel_in)
        4'b0001, 4'b0010, 4'b0100, 4'b1000:
                 addr_err = (mem_sel_in != (4'b0001 << result_in[1:0]));
        4'b0011: addr_err = (result_in[1:0] != 2'b00);
        4'b1100: addr_err = (result_in[1:0] != 2'b10);
        4'b1111: addr_err = (result_in[1:0] != 2'b00);
        default: addr_err = 1'b1;
      endcase
    end
  end
  assign addr_err_out = addr_err;
`else
  assign addr_err = 1'b0;
`endif

  assign start         = (state == IDLE) && pending && !addr_err;
  assign stall_request = start || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)             state_next = BUSY;
      BUSY:    if (ram.ack)           state_next = DONE;
      DONE:    if (!stall_next_stage) state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    case (mem_sel_in)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wdata_rep = {4{mem_write_data_in[7:0]}};
      4'b0011, 4'b1100:                   wdata_rep = {2{mem_write_data_in[15:0]}};
      default:                            wdata_rep = mem_write_data_in;
    endcase
  end

  always_comb begin
    case (mem_sel_in)
      4'b0001: load_data = {{24{mem_sign_ext_flag_in & ram.rdata[7]}},  ram.rdata[7:0]};
      4'b0010: load_data = {{24{mem_sign_ext_flag_in & ram.rdata[15]}}, ram.rdata[15:8]};
      4'b0100: load_data = {{24{mem_sign_ext_flag_in & ram.rdata[23]}}, ram.rdata[23:16]};
      4'b1000: load_data = {{24{mem_sign_ext_flag_in & ram.rdata[31]}}, ram.rdata[31:24]};
      4'b0011: load_data = {{16{mem_sign_ext_flag_in & ram.rdata[15]}}, ram.rdata[15:0]};
      4'b1100: load_data = {{16{mem_sign_ext_flag_in & ram.rdata[31]}}, ram.rdata[31:16]};
      default: load_data = ram.rdata;
    endcase
  end

  // Bus fields are only loaded on IDLE->BUSY so they stay frozen for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram.req   <= 1'b0;
      ram.we    <= 1'b0;
      ram.addr  <= '0;
      ram.sel   <= '0;
      ram.wdata <= '0;
      load_buf  <= '0;
    end else if (start) begin
      ram.req   <= 1'b1;
      ram.we    <= mem_write_flag_in;
      ram.addr  <= {result_in[31:2], 2'b00};
      ram.sel   <= mem_sel_in;
      ram.wdata <= wdata_rep;
    end else if (state == BUSY && ram.ack) begin
      ram.req <= 1'b0;
      if (mem_read_flag_in) load_buf <= load_data;
    end
  end

  always_comb begin
    result_out        = result_in;
    reg_write_en_out  = reg_write_en_in;
    hilo_write_en_out = hilo_write_en_in;
    if (pending) begin
      if (state == DONE) begin
        result_out = mem_read_flag_in ? load_buf : result_in;
      end else begin
        result_out        = '0;
        reg_write_en_out  = 1'b0;
        hilo_write_en_out = 1'b0;
      end
    end
  end

  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;
  assign hi_out              = hi_in;
  assign lo_out              = lo_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus hand-written multi-cycle sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_next_stage;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic        hilo_write_en_in;
  logic [31:0] hi_in, lo_in;
  logic        stall_request;
  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic        hilo_write_en_out;
  logic [31:0] hi_out, lo_out;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic        addr_err_out;
`endif

  int tests = 0;
  int fails = 0;

  mem_access_unit_if ram ();

  mem_access_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_next_stage    (stall_next_stage),
    .mem_read_flag_in    (mem_read_flag_in),
    .mem_write_flag_in   (mem_write_flag_in),
    .mem_sign_ext_flag_in(mem_sign_ext_flag_in),
    .mem_sel_in          (mem_sel_in),
    .mem_write_data_in   (mem_write_data_in),
    .result_in           (result_in),
    .reg_write_en_in     (reg_write_en_in),
    .reg_write_addr_in   (reg_write_addr_in),
    .current_pc_addr_in  (current_pc_addr_in),
    .hilo_write_en_in    (hilo_write_en_in),
    .hi_in               (hi_in),
    .lo_in               (lo_in),
    .ram                 (ram),
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    .addr_err_out        (addr_err_out),
`endif
    .stall_request       (stall_request),
    .result_out          (result_out),
    .reg_write_en_out    (reg_write_en_out),
    .reg_write_addr_out  (reg_write_addr_out),
    .current_pc_addr_out (current_pc_addr_out),
    .hilo_write_en_out   (hilo_write_en_out),
    .hi_out              (hi_out),
    .lo_out              (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sx;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned delay;
    logic [31:0] exp_result;
    logic [31:0] exp_wdata;
  } mem_vec_t;

  typedef struct {
    logic [31:0] result;
    logic        rwe;
    logic [4:0]  raddr;
    logic [31:0] pc;
    logic        hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        snx;
  } pt_vec_t;

  mem_vec_t vecs[13];
  pt_vec_t  pts[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata);
    mem_read_flag_in     = rd;
    mem_write_flag_in    = wr;
    mem_sign_ext_flag_in = sx;
    mem_sel_in           = sel;
    result_in            = addr;
    mem_write_data_in    = wdata;
    reg_write_en_in      = rd;
    hilo_write_en_in     = 1'b1;
    reg_write_addr_in    = 5'd7;
    current_pc_addr_in   = 32'h0000_4000;
  endtask

  // Entered at posedge+1 with the op about to start in IDLE; returns at posedge+1 after DONE.
  task automatic run_vec(input mem_vec_t v);
    set_op(v.rd, v.wr, v.sx, v.sel, v.addr, v.wdata);
    @(negedge clk);
    check("idle_stall", stall_request, 1);
    check("idle_req", ram.req, 0);
    check("idle_rwe", reg_write_en_out, 0);
    check("idle_hilo", hilo_write_en_out, 0);
    check("idle_result", result_out, 0);
    for (int unsigned k = 0; k <= v.delay; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("busy_req", ram.req, 1);
      check("busy_stall", stall_request, 1);
      check("busy_we", ram.we, v.wr);
      check("busy_addr", ram.addr, v.addr & 32'hFFFF_FFFC);
      check("busy_sel", ram.sel, v.sel);
      check("busy_wdata", ram.wdata, v.exp_wdata);
      check("busy_rwe", reg_write_en_out, 0);
      check("busy_result", result_out, 0);
      if (k == v.delay) begin
        ram.ack   = 1'b1;
        ram.rdata = v.rdata;
      end
    end
    @(posedge clk); #1;
    ram.ack   = 1'b0;
    ram.rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("done_stall", stall_request, 0);
    check("done_req", ram.req, 0);
    check("done_result", result_out, v.exp_result);
    check("done_rwe", reg_write_en_out, v.rd);
    check("done_hilo", hilo_write_en_out, 1);
    check("done_raddr", reg_write_addr_out, 7);
    @(posedge clk); #1;
  endtask

  initial begin
    //           rd    wr    sx    sel      addr          wdata         rdata         dly  exp_result    exp_wdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'b0100, 32'h0000_0102, 32'h0,        32'h0080_FF00, 0, 32'hFFFF_FF80, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 32'h0000_0102, 32'h0,        32'h0080_FF00, 0, 32'h0000_0080, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_0104, 32'h0,        32'h1234_5678, 0, 32'h0000_0078, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'b0010, 32'h0000_0105, 32'h0,        32'h0000_A500, 1, 32'hFFFF_FFA5, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 32'h0000_0107, 32'h0,        32'hF000_0000, 2, 32'h0000_00F0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_0108, 32'h0,        32'h0000_8001, 0, 32'hFFFF_8001, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 32'h0000_010A, 32'h0,        32'h8001_FFFF, 0, 32'h0000_8001, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'b1100, 32'h0000_010A, 32'h0,        32'h8001_FFFF, 0, 32'hFFFF_8001, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b1100, 32'h0000_0102, 32'h1234_ABCD, 32'h0,       3, 32'h0000_0102, 32'hABCD_ABCD};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0010, 32'h0000_0201, 32'h0000_00EE, 32'h0,       1, 32'h0000_0201, 32'hEEEE_EEEE};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       0, 32'h0000_0300, 32'hCAFE_F00D};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0000, 32'hFFFF_5566, 32'h0,       0, 32'h0000_0000, 32'h5566_5566};

    pts[0] = '{32'h1111_2222, 1'b1, 5'd3,  32'h0000_1000, 1'b0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0};
    pts[1] = '{32'hFFFF_FFFF, 1'b0, 5'd31, 32'hBFC0_0000, 1'b1, 32'h0,         32'hFFFF_FFFF, 1'b1};
    pts[2] = '{32'h0000_0003, 1'b1, 5'd0,  32'h8000_0004, 1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0};

    rst = 1'b1;
    stall_next_stage = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    hi_in = '0;
    lo_in = '0;
    ram.ack   = 1'b0;
    ram.rdata = 32'h5A5A_5A5A;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", ram.req, 0);
    check("rst_we", ram.we, 0);
    check("rst_addr", ram.addr, 0);
    check("rst_sel", ram.sel, 0);
    check("rst_wdata", ram.wdata, 0);
    check("rst_stall", stall_request, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (pts[i]) begin
      set_op(1'b0, 1'b0, 1'b0, 4'b1111, pts[i].result, 32'h0);
      reg_write_en_in    = pts[i].rwe;
      reg_write_addr_in  = pts[i].raddr;
      current_pc_addr_in = pts[i].pc;
      hilo_write_en_in   = pts[i].hilo;
      hi_in              = pts[i].hi;
      lo_in              = pts[i].lo;
      stall_next_stage   = pts[i].snx;
      @(negedge clk);
      check("pt_result", result_out, pts[i].result);
      check("pt_rwe", reg_write_en_out, pts[i].rwe);
      check("pt_raddr", reg_write_addr_out, pts[i].raddr);
      check("pt_pc", current_pc_addr_out, pts[i].pc);
      check("pt_hilo", hilo_write_en_out, pts[i].hilo);
      check("pt_hi", hi_out, pts[i].hi);
      check("pt_lo", lo_out, pts[i].lo);
      check("pt_stall", stall_request, 0);
      check("pt_req", ram.req, 0);
      @(posedge clk); #1;
    end
    stall_next_stage = 1'b0;

    // Back-to-back: each op starts in the cycle right after the previous DONE.
    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // DONE hold with stall_next_stage; stray ack and changed rdata must not disturb the result.
    set_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0400, 32'h0);
    @(negedge clk);
    check("hold_idle_stall", stall_request, 1);
    @(posedge clk); #1;
    @(negedge clk);
    ram.ack   = 1'b1;
    ram.rdata = 32'h1122_3344;
    @(posedge clk); #1;
    ram.ack          = 1'b0;
    ram.rdata        = 32'h9999_9999;
    stall_next_stage = 1'b1;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      check("hold_result", result_out, 32'h1122_3344);
      check("hold_req", ram.req, 0);
      check("hold_stall", stall_request, 0);
      check("hold_rwe", reg_write_en_out, 1);
      ram.ack = 1'b1;
      @(posedge clk); #1;
      ram.ack = 1'b0;
    end
    stall_next_stage = 1'b0;
    @(negedge clk);
    check("hold_release_result", result_out, 32'h1122_3344);
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0404, 32'h0);
    @(negedge clk);
    check("hold_after_req", ram.req, 0);
    check("hold_after_result", result_out, 32'h0000_0404);
    @(posedge clk); #1;

    // Reset in BUSY abandons the access; a late ack afterwards is ignored.
    set_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0500, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_busy_req", ram.req, 1);
    rst = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 4'b1111, 32'h0000_0500, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rb_req", ram.req, 0);
    check("rb_stall", stall_request, 0);
    check("rb_result", result_out, 32'h0000_0500);
    ram.ack   = 1'b1;
    ram.rdata = 32'h7777_7777;
    @(posedge clk); #1;
    ram.ack   = 1'b0;
    ram.rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("rb_late_req", ram.req, 0);
    check("rb_late_stall", stall_request, 0);
    check("rb_late_result", result_out, 32'h0000_0500);
    @(posedge clk); #1;
    run_vec(vecs[3]);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    set_op(1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000_0102, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mis_err", addr_err_out, 1);
      check("mis_req", ram.req, 0);
      check("mis_stall", stall_request, 0);
      check("mis_rwe", reg_write_en_out, 0);
      @(posedge clk); #1;
    end
    set_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    check("mis_clear_err", addr_err_out, 0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the CPU pipeline. It consumes the EX/MEM pipeline register outputs, runs a request/acknowledge transaction on the data-RAM port for loads and stores, and asserts a stall request while the access is outstanding. It also extracts and sign- or zero-extends load data, and presents the write-back payload to the MEM/WB register. Non-memory instructions pass through combinationally with no added cycles.

## Interface
Parameters: none. Widths come from the bus macros: DATA_BUS 32, ADDR_BUS 32, REG_ADDR_BUS 5, MEM_SEL_BUS 4.

- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall_next_stage  in  1  downstream/global stall; the pipeline will not advance this cycle.
- mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in  in  1 each  load, store, and sign-extend load.
- mem_sel_in  in  4  byte enables, lane-positioned.
- mem_write_data_in  in  32  store data, low-aligned.
- result_in  in  32  ALU result; this is the effective address for memory ops.
- reg_write_en_in, reg_write_addr_in (5), current_pc_addr_in (32), hilo_write_en_in, hi_in (32), lo_in (32)  in  write-back payload.
- ram_req  out  1  access request, registered.
- ram_we  out  1  1 = store.
- ram_addr  out  32  {result_in[31:2], 2'b00}.
- ram_sel  out  4  byte enables.
- ram_wdata  out  32  store data replicated across lanes.
- ram_rdata  in  32  read data; valid while ram_ack is high.
- ram_ack  in  1  transaction complete.
- stall_request  out  1  holds EX/MEM and earlier stages.
- result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out, hilo_write_en_out, hi_out, lo_out  out  same widths as inputs  payload to MEM/WB.

## Operation
- Access is pending when mem_read_flag_in or mem_write_flag_in is high.
- FSM states and transitions:
  - IDLE -> BUSY when an access is pending.
  - BUSY -> DONE when ram_ack is high.
  - DONE -> IDLE when stall_next_stage is low; DONE holds while stall_next_stage is high.
- ram_req, ram_we, ram_addr, ram_sel and ram_wdata are registered on the IDLE->BUSY edge. They stay stable for the whole of BUSY, and ram_req clears on the edge that leaves BUSY.
- ram_wdata replication by mem_sel_in:
  - byte sel (0001/0010/0100/1000) -> {4{data[7:0]}}
  - 0011/1100 -> {2{data[15:0]}}
  - any other value -> data
- Load extraction, done on ack and stored in a 32-bit load buffer:
  - 0001 -> [7:0], 0010 -> [15:8], 0100 -> [23:16], 1000 -> [31:24]
  - 0011 -> [15:0], 1100 -> [31:16]
  - otherwise the full word
  - mem_sign_ext_flag_in selects sign extension; otherwise zero extension.
- stall_request = (IDLE and access pending) or BUSY.
- Output payload:
  - Non-memory op in IDLE: all outputs equal their inputs.
  - Memory op before DONE: reg_write_en_out and hilo_write_en_out are forced to 0 (bubble), and result_out is 0.
  - Memory op in DONE: result_out is the load buffer for a load, or result_in for a store; the remaining outputs pass through.
- A ram_ack arriving in IDLE or DONE is ignored.
- Reset: state goes to IDLE; ram_req, ram_we, ram_sel, ram_addr, ram_wdata and the load buffer go to 0; stall_request deasserts in the next cycle. A reset during BUSY abandons the transaction.

## Timing
- Minimum latency for a memory op is 3 cycles:
  - cycle 0: IDLE, stall_request = 1.
  - cycle 1: BUSY, ram_req = 1; ack may arrive in this cycle.
  - cycle 2: DONE, stall_request = 0; MEM/WB captures at the end of cycle 2.
- Each cycle of ack delay adds one cycle.
- Non-memory ops take 0 added cycles, and stall_request stays 0.
- Back-to-back loads: DONE->IDLE on the same edge that EX/MEM advances, so the next access enters IDLE in the following cycle with no gap cycle lost.

## Configuration
- MEM_ACCESS_ALIGN_CHECK_EN defined:
  - IDLE checks mem_sel_in against result_in[1:0]:
    - a byte sel must equal 1<<addr[1:0]
    - 0011 requires addr 00, 1100 requires addr 10, 1111 requires addr 00
    - any other pattern is illegal
  - On a mismatch: no bus request, no stall, reg_write_en_out = 0, and an extra output addr_err_out (1 bit) = 1 combinationally.
- Undefined: no check is made, addr_err_out does not exist, and address bits [1:0] are ignored.

## Test plan
- Word load:
  - Stimulus: addr 0x100, sel 1111, ack in cycle 1, rdata 0xDEADBEEF.
  - Required: ram_req is high for exactly 1 cycle; in cycle 2 result_out = 0xDEADBEEF, reg_write_en_out = 1, stall_request = 0.
- Signed byte load:
  - Stimulus: sel 0100, sign_ext = 1, rdata 0x0080FF00.
  - Required: result_out = 0xFFFFFF80.
  - Repeat with sign_ext = 0: result_out = 0x00000080.
- Halfword store:
  - Stimulus: sel 1100, data 0x1234ABCD, ack delayed 3 cycles.
  - Required: ram_we = 1, ram_wdata = 0xABCDABCD, and ram_addr/ram_sel stay stable for 4 BUSY cycles.
  - stall_request is high for 5 cycles, and reg_write_en_out is 0 throughout.
- DONE hold:
  - Stimulus: stall_next_stage high for 2 cycles in DONE.
  - Required: the load result is held steady and no new ram_req is issued.
- Reset during BUSY:
  - Stimulus: assert rst, then apply a late ack.
  - Required: ram_req = 0 the next cycle, state is IDLE, the late ack is ignored, and result_out passes result_in.
- Misaligned access (MEM_ACCESS_ALIGN_CHECK_EN defined):
  - Stimulus: sel 0011 with addr 0x102.
  - Required: addr_err_out = 1, ram_req never asserts, stall_request = 0.
